// File: rtl/adc_dump_ctrl.sv
// Capture sequencer for the ADC dump SRAM: arms under JTAG, triggers on a synchronized
// rising edge of the external pin, writes N words and shares the SRAM port with readback.
module adc_dump_ctrl #(
   parameter int N_mem_addr = 10,
   parameter int N_holdoff  = 16
) (
   input  logic                  clk_adc,
   input  logic                  rstb,
   input  logic                  dump_start,
   input  logic                  en_dump,
   input  logic [N_mem_addr:0]   num_words,
   input  logic [N_holdoff-1:0]  holdoff,
   input  logic                  rd_req,
   input  logic [N_mem_addr-1:0] rd_addr,
   output logic                  mem_ce,
   output logic                  mem_we,
   output logic [N_mem_addr-1:0] mem_addr,
   output logic                  rd_gnt,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  done,
   output logic [N_mem_addr:0]   wr_count,
   output logic [2:0]            state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_HOLDOFF = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [N_mem_addr:0]  DEPTH    = {1'b1, {N_mem_addr{1'b0}}};
   localparam logic [N_holdoff-1:0] HOLD_ONE = {{(N_holdoff-1){1'b0}}, 1'b1};

   logic [2:0]            state_q;
   logic                  s1, s2, s3;
   logic [1:0]            sync_fill;
   logic                  low_seen;
   logic                  start_pulse;
   logic [N_holdoff-1:0]  hold_cnt;
   logic [N_mem_addr:0]   n_lat;
   logic [N_mem_addr:0]   n_eff;
   logic                  capture;

   // s2 only reflects the pin once the synchronizer has filled after reset; an edge
   // counts only after the pin has genuinely been seen low, so a pin held high
   // through reset cannot fire.
   always_ff @(posedge clk_adc or negedge rstb) begin
      if (!rstb) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         sync_fill <= 2'b00;
         low_seen  <= 1'b0;
      end else begin
         s1        <= dump_start;
         s2        <= s1;
         s3        <= s2;
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && !s2)
            low_seen <= 1'b1;
      end
   end

   assign start_pulse = s2 & ~s3 & low_seen;
   assign n_eff = ((num_words == '0) || (num_words > DEPTH)) ? DEPTH : num_words;

   always_ff @(posedge clk_adc or negedge rstb) begin
      if (!rstb) begin
         state_q  <= S_IDLE;
         hold_cnt <= '0;
         n_lat    <= '0;
         wr_count <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_dump)
                  state_q <= S_ARMED;
            end
            S_ARMED: begin
               if (!en_dump) begin
                  state_q <= S_IDLE;
               end else if (start_pulse) begin
                  hold_cnt <= holdoff;
                  n_lat    <= n_eff;
                  wr_count <= '0;
                  state_q  <= (holdoff != '0) ? S_HOLDOFF : S_CAPTURE;
               end
            end
            S_HOLDOFF: begin
               if (!en_dump) begin
                  state_q <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_ONE;
                  if (hold_cnt == HOLD_ONE)
                     state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               // wr_count doubles as the write address, so it stops at n_lat and never wraps
               if (!en_dump) begin
                  state_q <= S_IDLE;
               end else begin
                  wr_count <= wr_count + 1'b1;
                  if (wr_count == n_lat - 1'b1)
                     state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (!en_dump)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_adc or negedge rstb) begin
      if (!rstb)
         rd_valid <= 1'b0;
      else
         rd_valid <= rd_gnt;
   end

   // Readback handshake: rd_gnt is high in the same cycle as rd_req only while the
   // engine is IDLE or DONE; a refused request must be held by the requester, and the
   // granted read's data is valid one cycle later, flagged by rd_valid.
   assign capture = (state_q == S_CAPTURE);
   assign rd_gnt  = rd_req & ((state_q == S_IDLE) | (state_q == S_DONE));

   always_comb begin
      mem_ce   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      if (capture) begin
         mem_ce   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = wr_count[N_mem_addr-1:0];
      end else if (rd_gnt) begin
         mem_ce   = 1'b1;
         mem_addr = rd_addr;
      end
   end

   assign busy  = (state_q == S_ARMED) | (state_q == S_HOLDOFF) | capture;
   assign done  = (state_q == S_DONE);
   assign state = state_q;

endmodule

// File: tb/tb_adc_dump_ctrl.sv
// Directed and randomized checks of adc_dump_ctrl against a sequence-level model of
// a capture: expected holdoff length, write count and address list.
module tb_adc_dump_ctrl;

   localparam int AW    = 10;
   localparam int HW    = 16;
   localparam int DEPTH = 1 << AW;

   logic          clk_adc    = 1'b0;
   logic          rstb       = 1'b0;
   logic          dump_start = 1'b0;
   logic          en_dump    = 1'b0;
   logic [AW:0]   num_words  = '0;
   logic [HW-1:0] holdoff    = '0;
   logic          rd_req     = 1'b0;
   logic [AW-1:0] rd_addr    = '0;
   logic          mem_ce, mem_we, rd_gnt, rd_valid, busy, done;
   logic [AW-1:0] mem_addr;
   logic [AW:0]   wr_count;
   logic [2:0]    state;

   int total = 0;
   int bad   = 0;
   logic [AW:0] exp_q[$];

   always #5 clk_adc = ~clk_adc;

   adc_dump_ctrl #(.N_mem_addr(AW), .N_holdoff(HW)) dut (
      .clk_adc    (clk_adc),
      .rstb       (rstb),
      .dump_start (dump_start),
      .en_dump    (en_dump),
      .num_words  (num_words),
      .holdoff    (holdoff),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .mem_ce     (mem_ce),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .rd_gnt     (rd_gnt),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .done       (done),
      .wr_count   (wr_count),
      .state      (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_adc);
      #1;
   endtask

   function automatic int eff_n(input int nw);
      return (nw == 0 || nw > DEPTH) ? DEPTH : nw;
   endfunction

   // Arm from IDLE, hold the pin low long enough to be seen, then raise it and count
   // edges until the engine leaves ARMED (sync 2 flops + edge flop = 3 edges).
   task automatic fire(input int nw, input int ho, output int lat);
      num_words  = nw[AW:0];
      holdoff    = ho[HW-1:0];
      en_dump    = 1'b1;
      dump_start = 1'b0;
      repeat (4) tick();
      check("armed", state, 1);
      dump_start = 1'b1;
      lat = 0;
      while (state == 3'd1 && lat < 10) begin
         tick();
         lat++;
      end
      dump_start = 1'b0;
   endtask

   task automatic run_capture(input int nw, input int ho, input bit hammer);
      int lat, n;
      int ho_cyc   = 0;
      int nwr      = 0;
      int addr_err = 0;
      int gnt_err  = 0;
      int cyc      = 0;
      logic [AW:0] e;
      n = eff_n(nw);
      exp_q.delete();
      for (int a = 0; a < n; a++) exp_q.push_back((AW+1)'(a));
      fire(nw, ho, lat);
      check("trig_lat", lat, 3);
      while (state != 3'd4 && cyc < 3000) begin
         if (hammer) begin
            holdoff   = HW'($urandom);
            num_words = (AW+1)'($urandom);
            rd_req    = 1'($urandom_range(0, 1));
            rd_addr   = AW'($urandom);
         end
         #1;
         if (state == 3'd2) ho_cyc++;
         if (state == 3'd3) begin
            if (mem_we !== 1'b1 || mem_ce !== 1'b1) addr_err++;
            if (exp_q.size() == 0) addr_err++;
            else begin
               e = exp_q.pop_front();
               if (mem_addr !== e[AW-1:0]) addr_err++;
            end
            nwr++;
         end
         if (rd_gnt !== 1'b0) gnt_err++;
         tick();
         cyc++;
      end
      rd_req = 1'b0;
      #1;
      check("done_state", state, 4);
      check("done_flag", done, 1);
      check("busy_in_done", busy, 0);
      check("holdoff_cycles", ho_cyc, ho);
      check("write_count", nwr, n);
      check("addr_seq_errors", addr_err, 0);
      check("wr_count", wr_count, n);
      check("gnt_while_busy", gnt_err, 0);
      check("port_idle_done", {mem_ce, mem_we, mem_addr}, 0);
   endtask

   task automatic leave_done();
      tick();
      check("done_held", state, 4);
      en_dump = 1'b0;
      tick();
      check("back_idle", state, 0);
      check("done_cleared", done, 0);
   endtask

   initial begin
      int lat, k;
      // reset with the pin high
      dump_start = 1'b1;
      repeat (3) @(posedge clk_adc);
      #1;
      check("rst_state", state, 0);
      check("rst_port", {mem_ce, mem_we, mem_addr}, 0);
      check("rst_flags", {rd_gnt, rd_valid, busy, done}, 0);
      check("rst_wr_count", wr_count, 0);

      rstb    = 1'b1;
      en_dump = 1'b1;
      repeat (12) tick();
      check("no_trig_pin_high", state, 1);

      run_capture(8, 0, 1'b0);

      rd_req  = 1'b1;
      rd_addr = 10'd5;
      #1;
      check("rd_gnt_done", rd_gnt, 1);
      check("rd_port", {mem_ce, mem_we, mem_addr}, {1'b1, 1'b0, 10'd5});
      tick();
      check("rd_valid", rd_valid, 1);
      rd_req = 1'b0;
      tick();
      check("rd_valid_drop", rd_valid, 0);
      leave_done();

      run_capture(4, 5, 1'b1);
      leave_done();
      run_capture(0, $urandom_range(0, 3), 1'b0);
      leave_done();
      run_capture(2047, 2, 1'b1);
      leave_done();
      repeat (4) begin
         run_capture($urandom_range(1, 40), $urandom_range(0, 12), 1'b1);
         leave_done();
      end

      // abort after the third write
      fire(8, 0, lat);
      k = 0;
      while (wr_count != 3 && k < 20) begin
         tick();
         k++;
      end
      check("abort_reach3", wr_count, 3);
      en_dump = 1'b0;
      tick();
      check("abort_state", state, 0);
      check("abort_we", mem_we, 0);
      check("abort_wr_count", wr_count, 3);
      check("abort_flags", {busy, done}, 0);
      tick();
      check("idle_holds_count", wr_count, 3);

      // asynchronous reset mid-capture
      fire(50, 0, lat);
      repeat (5) tick();
      check("pre_rst_capture", state, 3);
      #3;
      rstb = 1'b0;
      #1;
      check("arst_state", state, 0);
      check("arst_port", {mem_ce, mem_we, mem_addr}, 0);
      check("arst_flags", {busy, done, rd_valid}, 0);
      check("arst_wr_count", wr_count, 0);
      en_dump = 1'b0;
      tick();
      rstb = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
